imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//   Shares the single-port, word-organised instruction memory between two requesters:
//   the IF-stage fetch (read) and the program loader (write, boot/debug).
//   Sits between the fetch stage/loader and the instruction memory array.
//   Drives the memory enable/write/address lines, returns read data with a valid flag,
//   and guarantees fetch progress via a loader burst limit.
// PARAMETERS
//   ADDR_W       10  word-address width of the memory (1024 x 32 words)
//   MAX_L_BURST  4   consecutive loader grants allowed before a waiting fetch wins
// PORTS
//   clk       in   1       clock, all state updates on rising edge
//   rst       in   1       synchronous reset, active-high
//   f_req     in   1       fetch request (read)
//   f_addr    in   32      fetch byte address
//   f_gnt     out  1       fetch granted this cycle (combinational)
//   f_rvalid  out  1       fetch response valid (registered, one cycle after f_gnt)
//   f_rdata   out  32      fetch instruction word; 0 when f_rvalid=0 or f_err=1
//   f_err     out  1       fetch response error (misaligned/out of range); qualified by f_rvalid
//   l_req     in   1       loader write request
//   l_addr    in   32      loader byte address
//   l_wdata   in   32      loader write data
//   l_gnt     out  1       loader granted this cycle (combinational)
//   l_err     out  1       one-cycle pulse, cycle after a loader grant whose write was dropped
//   m_en      out  1       memory access enable
//   m_we      out  1       memory write enable (only with m_en)
//   m_addr    out  ADDR_W  memory word index = selected addr[ADDR_W+1:2]
//   m_wdata   out  32      memory write data (= l_wdata when loader granted, else 0)
//   m_rdata   in   32      memory read data, valid the cycle after m_en & !m_we
// BEHAVIOUR
//   - Reset (rst=1 at edge): cnt<=0, f_rvalid<=0, f_err<=0, l_err<=0; pending response discarded.
//     While rst=1: f_gnt=l_gnt=m_en=m_we=0, m_addr=0, m_wdata=0.
//   - Arbitration (combinational, at most one grant per cycle), burst counter cnt in 0..MAX_L_BURST:
//       only f_req            -> fetch wins
//       only l_req            -> loader wins
//       both, cnt<MAX_L_BURST -> loader wins
//       both, cnt==MAX_L_BURST-> fetch wins
//       neither               -> no grant, m_en=0
//   - cnt update: loader win -> cnt<=min(cnt+1,MAX_L_BURST); fetch win or idle -> cnt<=0.
//   - Address check: ok = (addr[1:0]==0) && (addr[31:ADDR_W+2]==0).
//   - Fetch win: f_gnt=1. If ok: m_en=1, m_we=0, m_addr=f_addr word index.
//     If !ok: m_en=0. Next cycle: f_rvalid=1, f_err=!ok, f_rdata = ok ? m_rdata : 0.
//     Read latency exactly 1 cycle; back-to-back fetches give f_rvalid every cycle.
//   - Loader win: l_gnt=1. If ok: m_en=1, m_we=1, m_addr=l_addr word index, m_wdata=l_wdata.
//     If !ok: no memory access, l_err=1 next cycle.
//   - Requesters hold req/addr/wdata stable until granted; a request counts as consumed
//     in its grant cycle. No outstanding-request limit beyond one read in flight.
//   - rst asserted while a read is in flight: f_rvalid=0 the next cycle; the response is lost.
//   - Write then read to the same word in consecutive cycles returns the new data
//     (memory writes at the edge).
// TESTING
//   1 Reset: hold rst 2 cycles with f_req=l_req=1 -> all grants/m_en 0; f_rvalid=0 after release edge.
//   2 Fetch stream: f_req=1, f_addr=0,4,8 -> f_gnt each cycle, m_addr=0,1,2;
//     f_rvalid=1 with mem[0],mem[1],mem[2] one cycle later.
//   3 Starvation guard: f_req=l_req=1 held, MAX_L_BURST=4 -> grants L,L,L,L,F,L,L,L,L,F...
//   4 Loader write 0x0062E233 to 0x10, then fetch 0x10 -> m_we=1, m_addr=4;
//     the fetch returns 0x0062E233.
//   5 Errors: fetch 0x6 -> f_rvalid=1, f_err=1, f_rdata=0, m_en=0;
//     loader addr 0x1000 -> l_gnt=1, m_en=0, l_err pulse.
//   6 Reset mid-read: grant fetch at 0x8, assert rst next cycle -> f_rvalid=0 and cnt=0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Instruction memory port arbiter.
// Shares one single-port word memory between the fetch stage (reads) and the
// program loader (writes). The loader normally has priority, but after
// MAX_L_BURST consecutive loader grants a waiting fetch is served so the
// pipeline always makes progress. Misaligned or out-of-range requests are
// granted (consumed) without touching the memory and are reported as errors.
module imem_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int MAX_L_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester (read)
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  // loader requester (write)
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_err,
  // memory side
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int CNT_W = $clog2(MAX_L_BURST + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             f_rvalid_reg;
  logic             f_err_reg;
  logic             l_err_reg;

  logic [31:0]      req_addr [2];
  logic [1:0]       addr_ok;
  logic             f_ok;
  logic             l_ok;
  logic             burst_full;
  logic             f_win;
  logic             l_win;

  // Index 0 is the fetch port, index 1 the loader port.
  assign req_addr[0] = f_addr;
  assign req_addr[1] = l_addr;

  // An address is usable only if word aligned and inside the memory.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_addr_chk
      assign addr_ok[gi] = (req_addr[gi][1:0] == 2'b00) &&
                           (req_addr[gi][31:ADDR_W+2] == '0);
    end
  endgenerate

  assign f_ok = addr_ok[0];
  assign l_ok = addr_ok[1];

  // Loader wins unless it has used up its burst allowance while fetch waits.
  assign burst_full = (cnt_reg == CNT_W'(MAX_L_BURST));
  assign f_win      = !rst && f_req && (!l_req || burst_full);
  assign l_win      = !rst && l_req && !f_win;

  assign f_gnt   = f_win;
  assign l_gnt   = l_win;

  // Bad addresses are consumed without any memory access.
  assign m_en    = (f_win && f_ok) || (l_win && l_ok);
  assign m_we    = l_win && l_ok;
  assign m_addr  = f_win ? f_addr[ADDR_W+1:2] :
                   l_win ? l_addr[ADDR_W+1:2] : '0;
  assign m_wdata = l_win ? l_wdata : '0;

  // Read data comes straight from the memory's registered output, so it is
  // gated here to read as zero whenever there is no good response.
  assign f_rvalid = f_rvalid_reg;
  assign f_err    = f_err_reg;
  assign f_rdata  = (f_rvalid_reg && !f_err_reg) ? m_rdata : '0;
  assign l_err    = l_err_reg;

  // Burst counter: counts consecutive loader wins, saturating; any other cycle clears it.
  always_comb begin
    cnt_next = '0;
    if (l_win) begin
      cnt_next = burst_full ? cnt_reg : cnt_reg + 1'b1;
    end
  end

  // Registered state: burst count and one-cycle-delayed response/error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      f_rvalid_reg <= 1'b0;
      f_err_reg    <= 1'b0;
      l_err_reg    <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      f_rvalid_reg <= f_win;
      f_err_reg    <= f_win && !f_ok;
      l_err_reg    <= l_win && !l_ok;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: directed steps drive the requesters
// and check the combinational grant/memory outputs; expected fetch responses
// and loader error pulses are queued and checked by a separate monitor.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        l_req;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_err;
  logic        m_en;
  logic        m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  logic [32:0] fq [$];
  int          lq [$];
  logic [31:0] mem [1024];

  imem_port_arbiter #(.ADDR_W(10), .MAX_L_BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .f_err    (f_err),
    .l_req    (l_req),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_gnt    (l_gnt),
    .l_err    (l_err),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: synchronous write, registered read.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endfunction

  // Monitor: pops the scoreboard when the DUT presents a response.
  always @(negedge clk) begin
    bit         exp_le;
    logic [32:0] e;
    if (!rst) begin
      if (f_rvalid) begin
        if (fq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL f_resp: unexpected response err=%b data=%h, none required", f_err, f_rdata);
        end else begin
          e = fq.pop_front();
          $display("resp: err=%b data=%h", f_err, f_rdata);
          chk("f_resp", 64'({f_err, f_rdata}), 64'(e));
        end
      end
      exp_le = (lq.size() > 0) && (lq[0] == cyc);
      if (exp_le) void'(lq.pop_front());
      if (exp_le || l_err) chk("l_err", 64'(l_err), 64'(exp_le));
    end
  end

  // One cycle: drive inputs, queue expected responses, check grant/memory lines.
  task automatic step(input string nm, input logic r, input logic fr, input logic [31:0] fa,
                      input logic lr, input logic [31:0] la, input logic [31:0] lw,
                      input logic efg, input logic elg, input logic emen, input logic emwe,
                      input logic [9:0] ema, input logic pushf, input logic [32:0] fresp,
                      input logic pushl);
    @(posedge clk);
    #1;
    rst     = r;
    f_req   = fr;
    f_addr  = fa;
    l_req   = lr;
    l_addr  = la;
    l_wdata = lw;
    if (pushf) fq.push_back(fresp);
    if (pushl) lq.push_back(cyc + 1);
    @(negedge clk);
    $display("%s: f_gnt=%b l_gnt=%b m_en=%b m_we=%b m_addr=%0d", nm, f_gnt, l_gnt, m_en, m_we, m_addr);
    chk({nm, ".gnt"}, 64'({f_gnt, l_gnt, m_en, m_we}), 64'({efg, elg, emen, emwe}));
    if (emen) chk({nm, ".m_addr"}, 64'(m_addr), 64'(ema));
    chk({nm, ".m_wdata"}, 64'(m_wdata), 64'(elg ? lw : 32'h0));
  endtask

  task automatic f_only(input string nm, input logic [31:0] fa, input logic ok, input logic [31:0] data);
    step(nm, 1'b0, 1'b1, fa, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, ok, 1'b0, fa[11:2],
         1'b1, ok ? {1'b0, data} : {1'b1, 32'h0}, 1'b0);
  endtask

  task automatic l_only(input string nm, input logic [31:0] la, input logic [31:0] lw, input logic ok);
    step(nm, 1'b0, 1'b0, 32'h0, 1'b1, la, lw, 1'b0, 1'b1, ok, ok, la[11:2],
         1'b0, 33'h0, !ok);
  endtask

  task automatic both(input string nm, input logic [31:0] fa, input logic [31:0] la,
                      input logic [31:0] lw, input logic fwin, input logic [31:0] fdata);
    step(nm, 1'b0, 1'b1, fa, 1'b1, la, lw, fwin, !fwin, 1'b1, !fwin,
         fwin ? fa[11:2] : la[11:2], fwin, {1'b0, fdata}, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1);
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    m_rdata = 32'h0;
    rst     = 1'b1;
    f_req   = 1'b1;
    f_addr  = 32'h0;
    l_req   = 1'b1;
    l_addr  = 32'h40;
    l_wdata = 32'h0;

    // Reset held with both requesting: nothing granted, memory idle.
    step("rst0", 1'b1, 1'b1, 32'h0, 1'b1, 32'h40, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 33'h0, 1'b0);
    step("rst1", 1'b1, 1'b1, 32'h0, 1'b1, 32'h40, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 33'h0, 1'b0);
    step("rel",  1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 33'h0, 1'b0);
    chk("rst.f_rvalid", 64'(f_rvalid), 64'(0));

    // Fetch stream, back to back.
    f_only("fs0", 32'h0, 1'b1, 32'hA500_0000);
    f_only("fs1", 32'h4, 1'b1, 32'hA500_0001);
    f_only("fs2", 32'h8, 1'b1, 32'hA500_0002);

    // Starvation guard: L,L,L,L,F,L,L,L,L,F.
    for (int k = 0; k < 10; k++)
      both($sformatf("burst%0d", k), 32'h20, 32'h40, 32'hDEAD_0001, (k == 4) || (k == 9), 32'hA500_0008);

    // Loader alone beyond the burst limit keeps winning; counter saturates,
    // so a fetch arriving next wins immediately.
    for (int k = 0; k < 6; k++)
      l_only($sformatf("lsat%0d", k), 32'h44, 32'h1234_5678, 1'b1);
    both("sat_f", 32'h44, 32'h44, 32'h9999_0000, 1'b1, 32'h1234_5678);
    both("sat_l", 32'h44, 32'h44, 32'h9999_0000, 1'b0, 32'h0);
    f_only("sat_rd", 32'h44, 1'b1, 32'h9999_0000);

    // Write then read the same word in consecutive cycles.
    l_only("wr10", 32'h10, 32'h0062_E233, 1'b1);
    f_only("rd10", 32'h10, 1'b1, 32'h0062_E233);

    // Misaligned / out-of-range requests.
    f_only("fmis",   32'h6,    1'b0, 32'h0);
    l_only("lrange", 32'h1000, 32'hBAD0_BAD0, 1'b0);
    f_only("frange", 32'h1000, 1'b0, 32'h0);
    l_only("lmis",   32'h42,   32'h5555_AAAA, 1'b0);

    // Reset while a read is in flight: the response is lost and cnt restarts.
    step("rmid_f",   1'b0, 1'b1, 32'h8, 1'b0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 10'd2, 1'b0, 33'h0, 1'b0);
    step("rmid_rst", 1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 33'h0, 1'b0);
    both("rmid0", 32'h20, 32'h40, 32'h77, 1'b0, 32'h0);
    chk("rmid.f_rvalid", 64'(f_rvalid), 64'(0));
    both("rmid1", 32'h20, 32'h40, 32'h77, 1'b0, 32'h0);
    both("rmid2", 32'h20, 32'h40, 32'h77, 1'b0, 32'h0);
    both("rmid3", 32'h20, 32'h40, 32'h77, 1'b0, 32'h0);
    both("rmid4", 32'h20, 32'h40, 32'h77, 1'b1, 32'hA500_0008);

    // Drain and confirm every expected response was delivered.
    step("idle0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 33'h0, 1'b0);
    step("idle1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 33'h0, 1'b0);
    chk("drain.fq", 64'(fq.size()), 64'(0));
    chk("drain.lq", 64'(lq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
